// File: rtl/float_struct.sv
// float_struct: shared FP result states, IEEE-754 single constants and unpacked operand layout.
package float_struct;
  typedef enum logic [1:0] {OK = 2'b00, NAN = 2'b01, INF = 2'b10, NUL = 2'b11} states;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX = 255;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  typedef struct packed {
    logic              sign;
    logic signed [9:0] exp;
    logic [26:0]       mant;
  } operand_t;
endpackage

// File: rtl/leading_zero_counter.sv
// leading_zero_counter: combinational count of zeros above the most significant set bit.
module leading_zero_counter #(
  parameter int WIDTH = 26,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CW-1:0]    o_count
);
  always_comb begin
    o_count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) if (i_data[i]) o_count = CW'(WIDTH - 1 - i);
  end
endmodule

// File: rtl/floating_point_normalizer.sv
// floating_point_normalizer: normalize, round-to-nearest-even and pack an adder result into an IEEE-754 single.
module floating_point_normalizer
  import float_struct::*;
#(
  parameter int EXP_W  = 10,
  parameter int MANT_W = 27
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_vld,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [MANT_W-1:0]       in_mant,
  input  logic                    in_sticky,
  input  logic                    in_nan,
  input  logic                    in_inf,
  output logic [31:0]             result,
  output states                   state,
  output logic                    res_vld
);
  // two bits of headroom so carry increments and large left shifts never wrap
  localparam int XW = EXP_W + 2;
  localparam int LW = $clog2(MANT_W);
  localparam int FW = MANT_W - 4;
  localparam logic signed [XW-1:0] X_ONE = XW'(1);
  localparam logic signed [XW-1:0] X_MAX = XW'(EXP_MAX);
  logic [2:0] r_vld;
  logic r1_sign, r1_sticky, r1_nan, r1_inf, r1_zero;
  logic signed [EXP_W-1:0] r1_exp;
  logic [MANT_W-1:0] r1_mant;
  logic [LW-1:0] r1_lzc, w_lzc;
  logic r2_sign, r2_sticky, r2_nan, r2_inf, r2_zero;
  logic signed [XW-1:0] r2_exp, w_exp;
  logic [MANT_W-3:0] r2_mant;
  logic [FW:0] w_frac;
  logic w_up;
  states w_state;
  logic [31:0] w_result;
  leading_zero_counter #(.WIDTH(MANT_W - 1)) u_lzc (
    .i_data (in_mant[MANT_W-2:0]),
    .o_count(w_lzc)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_vld     <= '0;
      r1_sign   <= 1'b0;
      r1_sticky <= 1'b0;
      r1_nan    <= 1'b0;
      r1_inf    <= 1'b0;
      r1_zero   <= 1'b0;
      r1_exp    <= '0;
      r1_mant   <= '0;
      r1_lzc    <= '0;
      r2_sign   <= 1'b0;
      r2_sticky <= 1'b0;
      r2_nan    <= 1'b0;
      r2_inf    <= 1'b0;
      r2_zero   <= 1'b0;
      r2_exp    <= '0;
      r2_mant   <= '0;
      result    <= '0;
      state     <= OK;
    end else begin
      r_vld <= {r_vld[1:0], in_vld};
      if (in_vld) begin
        r1_sign   <= in_sign;
        r1_sticky <= in_sticky;
        r1_nan    <= in_nan;
        r1_inf    <= in_inf;
        r1_zero   <= ~|in_mant;
        r1_exp    <= in_exp;
        r1_mant   <= in_mant;
        r1_lzc    <= w_lzc;
      end
      if (r_vld[0]) begin
        r2_sign   <= r1_sign;
        r2_nan    <= r1_nan;
        r2_inf    <= r1_inf;
        r2_zero   <= r1_zero;
        r2_sticky <= r1_sticky | (r1_mant[MANT_W-1] & r1_mant[0]);
        r2_exp    <= r1_mant[MANT_W-1] ? XW'(r1_exp) + X_ONE : XW'(r1_exp) - XW'(r1_lzc);
        r2_mant   <= (MANT_W - 2)'(r1_mant[MANT_W-1] ? r1_mant >> 1 : r1_mant << r1_lzc);
      end
      if (r_vld[1]) begin
        result <= w_result;
        state  <= w_state;
      end
    end
  // hidden bit is implicitly 1 here, so a carry out of the fraction means mantissa overflow
  assign w_up     = r2_mant[1] & (r2_mant[0] | r2_sticky | r2_mant[2]);
  assign w_frac   = {1'b0, r2_mant[MANT_W-3:2]} + {{FW{1'b0}}, w_up};
  assign w_exp    = w_frac[FW] ? r2_exp + X_ONE : r2_exp;
  assign w_state  = r2_nan ? NAN : r2_inf ? INF : r2_zero ? NUL :
                    w_exp >= X_MAX ? INF : w_exp < X_ONE ? NUL : OK;
  assign w_result = w_state == NAN ? QNAN :
                    w_state == INF ? {r2_sign, 8'hFF, 23'h0} :
                    w_state == NUL ? {r2_sign, 31'h0} :
                    {r2_sign, w_exp[7:0], w_frac[FW-1:0]};
  assign res_vld  = r_vld[2];
endmodule

// File: tb/tb_floating_point_normalizer.sv
// tb_floating_point_normalizer: directed and random checks against an MSB-position rounding model.
module tb_floating_point_normalizer;
  import float_struct::*;
  logic clk = 1'b0, rst = 1'b0, in_vld = 1'b0, in_sign = 1'b0;
  logic in_sticky = 1'b0, in_nan = 1'b0, in_inf = 1'b0;
  logic signed [9:0] in_exp = '0;
  logic [26:0] in_mant = '0;
  logic [31:0] result;
  states state;
  logic res_vld;
  int n_chk = 0, n_pass = 0;
  logic pv[$];
  logic [31:0] pr[$];
  states ps[$];
  string pt[$];
  logic [31:0] last_res = '0, cur_res = '0;
  states last_st = OK, cur_st = OK;
  string cur_tag = "idle";
  logic [33:0] w;
  logic r_s, r_st, r_n, r_i;
  int r_e, r_k;
  logic [26:0] r_m;

  floating_point_normalizer dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_sign(in_sign), .in_exp(in_exp),
    .in_mant(in_mant), .in_sticky(in_sticky), .in_nan(in_nan), .in_inf(in_inf),
    .result(result), .state(state), .res_vld(res_vld)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Value = m * 2^(e-25); locate the MSB, keep 24 significant bits, round the rest to nearest even.
  function automatic logic [33:0] model(input logic s, input int e, input logic [26:0] m,
                                        input logic st, input logic nan, input logic inf);
    int p = -1;
    int ex, k, sig, rem, half;
    logic [31:0] fr;
    if (nan) return {NAN, 32'h7FC00000};
    if (inf) return {INF, s, 8'hFF, 23'h0};
    if (m == 0) return {NUL, s, 31'h0};
    for (int i = 0; i < 27; i++) if (m[i]) p = i;
    ex = e + p - 25;
    if (p > 23) begin
      k = p - 23;
      sig = int'(m) >> k;
      rem = int'(m) % (1 << k);
      half = 1 << (k - 1);
      if (rem > half || (rem == half && (st || sig % 2 == 1))) sig++;
    end else sig = int'(m) << (23 - p);
    if (sig == (1 << 24)) begin
      sig = 1 << 23;
      ex++;
    end
    if (ex >= 255) return {INF, s, 8'hFF, 23'h0};
    if (ex <= 0) return {NUL, s, 31'h0};
    fr = sig;
    return {OK, s, 8'(ex), fr[22:0]};
  endfunction

  task automatic cyc();
    logic v;
    logic [31:0] r;
    states q;
    string t;
    pv.push_back(in_vld);
    pr.push_back(cur_res);
    ps.push_back(cur_st);
    pt.push_back(cur_tag);
    @(posedge clk);
    #1;
    if (pv.size() == 3) begin
      v = pv.pop_front();
      r = pr.pop_front();
      q = ps.pop_front();
      t = pt.pop_front();
      if (v) begin
        last_res = r;
        last_st = q;
      end
      check($sformatf("%s.res_vld", t), 32'(res_vld), 32'(v));
      check($sformatf("%s.result", t), result, last_res);
      check($sformatf("%s.state", t), 32'(state), 32'(last_st));
    end
  endtask

  task automatic beat(input string t, input logic s, input int e, input logic [26:0] m,
                      input logic st, input logic nan, input logic inf,
                      input logic [31:0] r, input states q);
    in_vld = 1'b1;
    in_sign = s;
    in_exp = 10'(e);
    in_mant = m;
    in_sticky = st;
    in_nan = nan;
    in_inf = inf;
    cur_tag = t;
    cur_res = r;
    cur_st = q;
    cyc();
  endtask

  task automatic idle(input int n);
    in_vld = 1'b0;
    cur_tag = "idle";
    repeat (n) cyc();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset.res_vld", 32'(res_vld), 32'd0);
    check("reset.result", result, 32'd0);
    check("reset.state", 32'(state), 32'(OK));
    rst = 1'b1;
    beat("one", 0, 127, 27'h2000000, 0, 0, 0, 32'h3F800000, OK);
    idle(3);
    beat("carry", 0, 127, 27'h4000000, 0, 0, 0, 32'h40000000, OK);
    beat("cancel", 0, 127, 27'h0000004, 0, 0, 0, 32'h34000000, OK);
    beat("rne_even", 0, 127, 27'h2000002, 0, 0, 0, 32'h3F800000, OK);
    beat("rne_odd", 0, 127, 27'h2000006, 0, 0, 0, 32'h3F800002, OK);
    beat("rne_sticky", 0, 127, 27'h2000002, 1, 0, 0, 32'h3F800001, OK);
    beat("round_carry", 0, 127, 27'h3FFFFFE, 0, 0, 0, 32'h40000000, OK);
    idle(2);
    beat("overflow", 0, 254, 27'h4000000, 0, 0, 0, 32'h7F800000, INF);
    beat("underflow", 1, 1, 27'h1000000, 0, 0, 0, 32'h80000000, NUL);
    beat("nan", 1, 127, 27'h2000000, 0, 1, 1, 32'h7FC00000, NAN);
    beat("inf", 1, 127, 27'h2000000, 0, 0, 1, 32'hFF800000, INF);
    beat("zero", 0, 127, 27'h0000000, 1, 0, 0, 32'h00000000, NUL);
    idle(3);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else begin
        r_s = 1'($urandom_range(0, 1));
        r_e = int'($urandom_range(0, 300)) - 20;
        r_k = int'($urandom_range(1, 27));
        r_m = 27'($urandom & ((1 << r_k) - 1));
        r_st = 1'($urandom_range(0, 1));
        r_n = ($urandom_range(0, 15) == 0);
        r_i = ($urandom_range(0, 15) == 0);
        w = model(r_s, r_e, r_m, r_st, r_n, r_i);
        beat("rand", r_s, r_e, r_m, r_st, r_n, r_i, w[31:0], states'(w[33:32]));
      end
    end
    idle(3);
    beat("drop_a", 0, 127, 27'h2000000, 0, 0, 0, 32'h3F800000, OK);
    beat("drop_b", 0, 128, 27'h2000000, 0, 0, 0, 32'h40000000, OK);
    in_vld = 1'b0;
    rst = 1'b0;
    #1;
    check("midreset.res_vld", 32'(res_vld), 32'd0);
    check("midreset.result", result, 32'd0);
    check("midreset.state", 32'(state), 32'(OK));
    pv.delete();
    pr.delete();
    ps.delete();
    pt.delete();
    last_res = '0;
    last_st = OK;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(6);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
